// File: rtl/selector_pipe.sv
// selector_pipe: single-stage registered operation selector with a
// valid/ready handshake on both sides and an internal accumulator.
// Optional feature: define SELECTOR_PIPE_PARITY_EN to add the 'par' output
// (XOR-reduction of q, registered alongside q).
module selector_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             carry
`ifdef SELECTOR_PIPE_PARITY_EN
  ,
  output logic             par
`endif
);

`ifdef SELECTOR_PIPE_PARITY_EN
  // Even-parity bit over a result word
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] res_s;
  logic             res_carry_s;
  logic [WIDTH-1:0] acc_next_s;
  logic [WIDTH:0]   sum_ab_s;
  logic [WIDTH:0]   sum_acc_s;
  logic             accept_s;

  // The output register can take a new result whenever it is empty or being drained
  assign in_ready = !out_valid || out_ready;
  assign accept_s = in_valid && in_ready;
  assign nq       = ~q;

  // One extra bit on each adder captures the carry-out
  assign sum_ab_s  = {1'b0, a} + {1'b0, b};
  assign sum_acc_s = {1'b0, acc_r} + {1'b0, a};

  // Operation decode: result, carry and next accumulator value for this sel
  always_comb begin
    res_s       = '0;
    res_carry_s = 1'b0;
    acc_next_s  = acc_r;
    case (sel)
      3'b000: res_s = a;
      3'b001: res_s = b;
      3'b010: res_s = a & b;
      3'b011: res_s = a | b;
      3'b100: res_s = a ^ b;
      3'b101: begin
        res_s       = sum_ab_s[WIDTH-1:0];
        res_carry_s = sum_ab_s[WIDTH];
      end
      3'b110: begin
        acc_next_s  = sum_acc_s[WIDTH-1:0];
        res_s       = sum_acc_s[WIDTH-1:0];
        res_carry_s = sum_acc_s[WIDTH];
      end
      3'b111: begin
        acc_next_s = '0;
        res_s      = '0;
      end
      default: begin
        res_s       = '0;
        res_carry_s = 1'b0;
        acc_next_s  = acc_r;
      end
    endcase
  end

  // Output register and accumulator: load on transfer, drop valid on a bare drain, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
      carry     <= 1'b0;
      acc_r     <= '0;
`ifdef SELECTOR_PIPE_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (accept_s) begin
      out_valid <= 1'b1;
      q         <= res_s;
      carry     <= res_carry_s;
      acc_r     <= acc_next_s;
`ifdef SELECTOR_PIPE_PARITY_EN
      par       <= parity_of(res_s);
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/selector_pipe.md
SELECTOR_PIPE -- requirements
Module: selector_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, upstream offers sel/a/b.
REQ-005 SHALL have port in_ready, output, 1, block can accept a transaction this cycle.
REQ-006 SHALL have port sel, input, 3, operation code.
REQ-007 SHALL have ports a and b, input, WIDTH, operands.
REQ-008 SHALL have port out_valid, output, 1, q/nq/carry hold a result.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-010 SHALL have port q, output, WIDTH, registered result.
REQ-011 SHALL have port nq, output, WIDTH, always bitwise complement of q.
REQ-012 SHALL have port carry, output, 1, registered carry-out of arithmetic ops.

Function
REQ-013 SHALL transfer input only when in_valid and in_ready are both 1 at a rising edge.
REQ-014 SHALL drive in_ready = !out_valid || out_ready, combinationally, with no dependency on in_valid.
REQ-015 SHALL present the result of an accepted transfer on q/nq/carry with out_valid=1 exactly one cycle later.
REQ-016 SHALL compute on sel: 000 q=a; 001 q=b; 010 a&b; 011 a|b; 100 a^b; 101 a+b mod 2^WIDTH; 110 ACC; 111 CLR.
REQ-017 SHALL, for ACC, update internal WIDTH-bit register acc <= acc+a mod 2^WIDTH and set q to the new acc value.
REQ-018 SHALL, for CLR, set acc <= 0 and q <= 0, ignoring a and b.
REQ-019 SHALL set carry to the bit-WIDTH carry-out for sel 101 (a+b) and 110 (acc+a), and to 0 for all other codes.
REQ-020 SHALL modify acc only on an accepted transfer with sel 110 or 111; b is ignored for ACC.
REQ-021 SHALL hold q, nq, carry stable while out_valid=1 and out_ready=0.
REQ-022 SHALL clear out_valid when out_ready=1 and no new transfer occurs in that cycle.
REQ-023 SHALL, on simultaneous output drain and input transfer, load the new result with out_valid staying 1, sustaining one result per cycle.
REQ-024 SHALL ignore sel, a and b in any cycle without a transfer.

Reset
REQ-025 SHALL, while rst_n=0, force out_valid=0, q=0, nq=all ones, carry=0, acc=0 immediately, independent of clk.
REQ-026 SHALL discard any pending result on reset assertion mid-operation; no result from before reset appears afterwards.
REQ-027 SHALL drive in_ready=1 from the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL, with SELECTOR_PIPE_PARITY_EN defined, add output port par (1 bit), registered with q, equal to XOR-reduction of q, reset to 0, held under backpressure like q.
REQ-029 SHALL, without SELECTOR_PIPE_PARITY_EN, omit port par and its logic entirely; all other behaviour identical.

Verification (WIDTH=8)
REQ-030 SHALL verify: reset then sel=000 a=0x5A, in_valid=1 one cycle, out_ready=1 -> next cycle q=0x5A, nq=0xA5, out_valid=1, carry=0; following cycle out_valid=0.
REQ-031 SHALL verify: sel=101 a=0xF0 b=0x20 -> q=0x10, carry=1; sel=100 a=0xF0 b=0x3C -> q=0xCC, carry=0.
REQ-032 SHALL verify: out_ready=0 after a result with in_valid=1 held -> in_ready=0, q held 3+ cycles; out_ready=1 -> queued op result appears next cycle, nothing lost or duplicated.
REQ-033 SHALL verify: CLR, then ACC a=0x80 twice -> q=0x80 carry=0, then q=0x00 carry=1; ACC a=0x01 -> q=0x01.
REQ-034 SHALL verify: back-to-back transfers with out_ready=1 for 8 cycles, sel cycling 000..111 -> 8 consecutive results, out_valid continuously 1.
REQ-035 SHALL verify: rst_n pulsed low mid-stream with out_valid=1 -> out_valid=0, q=0x00, nq=0xFF, acc=0 (next ACC a=0x03 gives q=0x03); repeat with SELECTOR_PIPE_PARITY_EN, q=0x07 -> par=1.
